// File: rtl/sh_dir_stage_if.sv
// Request/response bundle for the shift direction stage.
// The master side issues requests and consumes results; the slave side is the stage itself.
interface sh_dir_stage_if #(
    parameter int W     = 32,
    parameter int AMT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [AMT_W-1:0] in_amt;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_zero;
    logic             out_err;

    modport master (
        output in_valid, in_op, in_amt, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_err
    );

    modport slave (
        input  in_valid, in_op, in_amt, in_data, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_err
    );
endinterface

// File: rtl/sh_dir_stage.sv
// Two-stage wrapper that maps SHL/SHR/SAR requests onto an external 32-bit left shifter.
// Stage 1 clamps the amount and pre-conditions the operand (reverse / invert) for the core;
// stage 2 undoes the conditioning on the core's combinational result and holds it for the consumer.
module sh_dir_stage #(
    parameter int W     = 32,
    parameter int AMT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    sh_dir_stage_if.slave  bus,
    output logic [5:0]     shl_n,
    output logic [W-1:0]   shl_in,
    input  logic [W-1:0]   shl_out
);
    localparam logic [1:0] OP_SHL = 2'b00;
    localparam logic [1:0] OP_SHR = 2'b01;
    localparam logic [1:0] OP_SAR = 2'b10;

    // stage 1 registers
    logic         s1_valid_q, s1_valid_d;
    logic [5:0]   s1_n_q, s1_n_d;
    logic [W-1:0] s1_in_q, s1_in_d;
    logic         s1_rev_q, s1_rev_d;
    logic         s1_sign_q, s1_sign_d;
    logic         s1_err_q, s1_err_d;

    // stage 2 (output) registers
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         out_zero_q, out_zero_d;
    logic         out_err_q, out_err_d;

    logic         in_xfer;
    logic         s1_adv;
    logic         in_ready_c;
    logic [W-1:0] in_pre;
    logic [W-1:0] in_rev;
    logic [W-1:0] out_rev;
    logic [W-1:0] res;

    // Bit reversal is pure wiring: one for the operand going in, one for the core result coming back.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_rev
            assign in_rev[gi]  = in_pre[W-1-gi];
            assign out_rev[gi] = shl_out[W-1-gi];
        end
    endgenerate

    // Handshake: stage 1 empties when stage 2 is free or being drained this cycle.
    always_comb begin
        s1_adv     = s1_valid_q && (!out_valid_q || bus.out_ready);
        in_ready_c = !s1_valid_q || s1_adv;
        in_xfer    = bus.in_valid && in_ready_c;
    end

    // Stage 1 next state: condition the request so every op becomes a left shift.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_n_d     = s1_n_q;
        s1_in_d    = s1_in_q;
        s1_rev_d   = s1_rev_q;
        s1_sign_d  = s1_sign_q;
        s1_err_d   = s1_err_q;
        // A negative SAR operand is inverted so the zeros shifted in become ones after un-inverting.
        in_pre     = (bus.in_op == OP_SAR && bus.in_data[W-1]) ? ~bus.in_data : bus.in_data;
        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_n_d     = (bus.in_amt >= AMT_W'(32)) ? 6'd32 : bus.in_amt[5:0];
            s1_rev_d   = 1'b0;
            s1_sign_d  = 1'b0;
            s1_err_d   = 1'b0;
            case (bus.in_op)
                OP_SHL: s1_in_d = bus.in_data;
                OP_SHR: begin
                    s1_in_d  = in_rev;
                    s1_rev_d = 1'b1;
                end
                OP_SAR: begin
                    s1_in_d   = in_rev;
                    s1_rev_d  = 1'b1;
                    s1_sign_d = bus.in_data[W-1];
                end
                default: begin
                    // illegal op: pass the operand through unshifted and flag it
                    s1_in_d  = bus.in_data;
                    s1_n_d   = 6'd0;
                    s1_err_d = 1'b1;
                end
            endcase
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage 2 next state: undo the conditioning on the core result and hold it for the consumer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_zero_d  = out_zero_q;
        out_err_d   = out_err_q;
        res         = shl_out;
        if (s1_rev_q) begin
            res = s1_sign_q ? ~out_rev : out_rev;
        end
        if (s1_adv) begin
            out_valid_d = 1'b1;
            out_data_d  = res;
            out_zero_d  = (res == '0);
            out_err_d   = s1_err_q;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Register both stages; reset empties the pipeline and drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_n_q      <= '0;
            s1_in_q     <= '0;
            s1_rev_q    <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_zero_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_n_q      <= s1_n_d;
            s1_in_q     <= s1_in_d;
            s1_rev_q    <= s1_rev_d;
            s1_sign_q   <= s1_sign_d;
            s1_err_q    <= s1_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_zero_q  <= out_zero_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_err   = out_err_q;
    assign shl_n         = s1_n_q;
    assign shl_in        = s1_in_q;
endmodule
